// File: rtl/dense_layer_mac.sv
// dense_layer_mac: fixed-point fully-connected layer y = act(W*x + b), LANES neurons per pass.
// Define DENSE_LAYER_SAT_EN to clamp outputs to the DATA_W range instead of wrapping.
module dense_layer_mac #(
   parameter int DATA_W    = 16,
   parameter int FRAC_W    = 8,
   parameter int N_INPUTS  = 784,
   parameter int N_NEURONS = 128,
   parameter int LANES     = 4,
   localparam int ACC_W    = 2*DATA_W + $clog2(N_INPUTS) + 1,
   localparam int N_GROUPS = N_NEURONS / LANES,
   localparam int WA_W     = (N_GROUPS*N_INPUTS > 1) ? $clog2(N_GROUPS*N_INPUTS) : 1,
   localparam int BA_W     = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
)(
   input  logic                      CLK,
   input  logic                      reset_n,
   input  logic                      relu_en,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W-1:0]         in_data,
   output logic [WA_W-1:0]           w_addr,
   input  logic [LANES*DATA_W-1:0]   w_rdata,
   output logic [BA_W-1:0]           b_addr,
   input  logic [LANES*DATA_W-1:0]   b_rdata,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_last,
   output logic                      busy
);

   localparam int CNT_W  = $clog2(N_INPUTS + 1);
   localparam int XI_W   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

   localparam logic [CNT_W-1:0]  N_IN_C      = CNT_W'(N_INPUTS);
   localparam logic [CNT_W-1:0]  LAST_IN_C   = CNT_W'(N_INPUTS - 1);
   localparam logic [CNT_W-1:0]  ONE_CNT_C   = CNT_W'(1'b1);
   localparam logic [BA_W-1:0]   LAST_GRP_C  = BA_W'(N_GROUPS - 1);
   localparam logic [LANE_W-1:0] LAST_LANE_C = LANE_W'(LANES - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      MAC  = 3'd2,
      BIAS = 3'd3,
      EMIT = 3'd4
   } state_t;

   state_t state_r, state_nx;

   logic [DATA_W-1:0]        x_mem [N_INPUTS];
   logic [CNT_W-1:0]         in_cnt_r;
   logic [CNT_W-1:0]         mac_cnt_r;
   logic [BA_W-1:0]          group_r;
   logic [LANE_W-1:0]        lane_r;
   logic [WA_W-1:0]          w_addr_r;
   logic                     relu_r;
   logic signed [ACC_W-1:0]  acc_r [LANES];
   logic [DATA_W-1:0]        res_r [LANES];
   logic [DATA_W-1:0]        out_data_r;
   logic                     out_valid_r;
   logic                     out_last_r;
   logic                     in_ready_r;
   logic                     busy_r;

   logic                     in_ready_d;
   logic                     busy_d;
   logic                     in_accept_s;
   logic                     out_accept_s;
   logic                     last_grp_s;
   logic                     last_lane_s;
   logic [XI_W-1:0]          wr_idx_s;
   logic [XI_W-1:0]          x_idx_s;
   logic signed [DATA_W-1:0] x_cur_s;
   logic [DATA_W-1:0]        w_lane_s   [LANES];
   logic [DATA_W-1:0]        b_lane_s   [LANES];
   logic [2*DATA_W-1:0]      prod_s     [LANES];
   logic [ACC_W-1:0]         prod_ext_s [LANES];
   logic signed [ACC_W-1:0]  sum_s      [LANES];
   logic [DATA_W-1:0]        res_s      [LANES];

   // Narrow a full-precision result to DATA_W: clamp or two's-complement wrap.
   function automatic logic [DATA_W-1:0] narrow(input logic signed [ACC_W-1:0] v);
`ifdef DENSE_LAYER_SAT_EN
      logic [ACC_W-DATA_W:0] upper;
      upper = v[ACC_W-1:DATA_W-1];
      if ((&upper) || !(|upper)) begin
         narrow = v[DATA_W-1:0];
      end else if (v[ACC_W-1]) begin
         narrow = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         narrow = {1'b0, {(DATA_W-1){1'b1}}};
      end
`else
      narrow = v[DATA_W-1:0];
`endif
   endfunction

   assign in_accept_s  = in_valid && in_ready_r;
   assign out_accept_s = out_valid_r && out_ready;
   assign last_grp_s   = (group_r == LAST_GRP_C);
   assign last_lane_s  = (lane_r == LAST_LANE_C);
   assign wr_idx_s     = (state_r == IDLE) ? '0 : XI_W'(in_cnt_r);

   assign in_ready  = in_ready_r;
   assign busy      = busy_r;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_last  = out_last_r;
   assign w_addr    = w_addr_r;
   assign b_addr    = group_r;

   // FSM state register.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nx = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               state_nx = (LAST_IN_C == '0) ? MAC : LOAD;
            end else begin
               state_nx = IDLE;
            end
         end
         LOAD: begin
            if (in_valid && (in_cnt_r == LAST_IN_C)) begin
               state_nx = MAC;
            end else begin
               state_nx = LOAD;
            end
         end
         MAC: begin
            if (mac_cnt_r == N_IN_C) begin
               state_nx = BIAS;
            end else begin
               state_nx = MAC;
            end
         end
         BIAS: state_nx = EMIT;
         EMIT: begin
            if (out_accept_s && last_lane_s) begin
               state_nx = last_grp_s ? IDLE : MAC;
            end else begin
               state_nx = EMIT;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // FSM output decode, evaluated on the next state so the handshake flags are registered.
   always_comb begin
      in_ready_d = 1'b0;
      busy_d     = 1'b1;
      case (state_nx)
         IDLE: begin
            in_ready_d = 1'b1;
            busy_d     = 1'b0;
         end
         LOAD:    in_ready_d = 1'b1;
         default: in_ready_d = 1'b0;
      endcase
   end

   // Registered handshake/status flags.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         in_ready_r <= 1'b1;
         busy_r     <= 1'b0;
      end else begin
         in_ready_r <= in_ready_d;
         busy_r     <= busy_d;
      end
   end

   // Input vector buffer; contents are don't-care until loaded, so no reset.
   always_ff @(posedge CLK) begin
      if (in_accept_s) begin
         x_mem[wr_idx_s] <= in_data;
      end
   end

   // Lane arithmetic: the ROM word in MAC cycle c belongs to x[c-1].
   always_comb begin
      x_idx_s = XI_W'(mac_cnt_r - 1'b1);
      x_cur_s = x_mem[x_idx_s];
      for (int j = 0; j < LANES; j++) begin
         w_lane_s[j]   = w_rdata[j*DATA_W +: DATA_W];
         b_lane_s[j]   = b_rdata[j*DATA_W +: DATA_W];
         prod_s[j]     = {{DATA_W{x_cur_s[DATA_W-1]}}, x_cur_s}
                       * {{DATA_W{w_lane_s[j][DATA_W-1]}}, w_lane_s[j]};
         prod_ext_s[j] = {{(ACC_W-2*DATA_W){prod_s[j][2*DATA_W-1]}}, prod_s[j]};
         sum_s[j]      = acc_r[j] + {{(ACC_W-DATA_W-FRAC_W){b_lane_s[j][DATA_W-1]}},
                                     b_lane_s[j], {FRAC_W{1'b0}}};
         if (relu_r && sum_s[j][ACC_W-1]) begin
            res_s[j] = '0;
         end else begin
            res_s[j] = narrow(sum_s[j] >>> FRAC_W);
         end
      end
   end

   // Counters, addresses, accumulators and the output element register.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         in_cnt_r    <= '0;
         mac_cnt_r   <= '0;
         group_r     <= '0;
         lane_r      <= '0;
         w_addr_r    <= '0;
         relu_r      <= 1'b0;
         out_data_r  <= '0;
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         for (int j = 0; j < LANES; j++) begin
            acc_r[j] <= '0;
            res_r[j] <= '0;
         end
      end else begin
         case (state_r)
            IDLE: begin
               mac_cnt_r <= '0;
               lane_r    <= '0;
               group_r   <= '0;
               w_addr_r  <= '0;
               if (in_accept_s) begin
                  in_cnt_r <= ONE_CNT_C;
                  relu_r   <= relu_en;
               end
            end
            LOAD: begin
               if (in_accept_s) begin
                  in_cnt_r <= in_cnt_r + 1'b1;
               end
            end
            MAC: begin
               for (int j = 0; j < LANES; j++) begin
                  acc_r[j] <= (mac_cnt_r == '0) ? '0 : acc_r[j] + prod_ext_s[j];
               end
               mac_cnt_r <= (mac_cnt_r == N_IN_C) ? '0 : mac_cnt_r + 1'b1;
               if (mac_cnt_r < LAST_IN_C) begin
                  w_addr_r <= w_addr_r + 1'b1;
               end
            end
            BIAS: begin
               for (int j = 0; j < LANES; j++) begin
                  res_r[j] <= res_s[j];
               end
               out_data_r  <= res_s[0];
               out_valid_r <= 1'b1;
               out_last_r  <= last_grp_s && (LAST_LANE_C == '0);
               lane_r      <= '0;
            end
            EMIT: begin
               if (out_accept_s) begin
                  if (last_lane_s) begin
                     out_valid_r <= 1'b0;
                     out_last_r  <= 1'b0;
                     lane_r      <= '0;
                     // Weight words of consecutive groups are contiguous.
                     if (last_grp_s) begin
                        group_r  <= '0;
                        w_addr_r <= '0;
                     end else begin
                        group_r  <= group_r + 1'b1;
                        w_addr_r <= w_addr_r + 1'b1;
                     end
                  end else begin
                     lane_r     <= lane_r + 1'b1;
                     out_data_r <= res_r[lane_r + 1'b1];
                     out_last_r <= last_grp_s && ((lane_r + 1'b1) == LAST_LANE_C);
                  end
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               out_last_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dense_layer_mac.sv
// Directed bench for dense_layer_mac with DATA_W=16 FRAC_W=8 N_INPUTS=4 N_NEURONS=4 LANES=2.
module tb_dense_layer_mac;

   logic        CLK = 1'b0;
   logic        reset_n;
   logic        relu_en;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [2:0]  w_addr;
   logic [31:0] w_rdata;
   logic [0:0]  b_addr;
   logic [31:0] b_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_last;
   logic        busy;

   logic [31:0] w_rom [8];
   logic [31:0] b_rom [2];

   int n_cmp = 0;
   int n_err = 0;

`ifdef DENSE_LAYER_SAT_EN
   localparam logic [15:0] T3_EXP = 16'h7FFF;
`else
   localparam logic [15:0] T3_EXP = 16'hFC00;
`endif

   dense_layer_mac #(
      .DATA_W(16), .FRAC_W(8), .N_INPUTS(4), .N_NEURONS(4), .LANES(2)
   ) dut (
      .CLK(CLK), .reset_n(reset_n), .relu_en(relu_en),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .w_addr(w_addr), .w_rdata(w_rdata), .b_addr(b_addr), .b_rdata(b_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy)
   );

   always #5 CLK = ~CLK;

   // Synchronous-read ROMs, one cycle of latency.
   always @(posedge CLK) begin
      w_rdata <= w_rom[w_addr];
      b_rdata <= b_rom[b_addr];
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // wn holds neuron n's weight at [n*16 +: 16]; every neuron gets bias bv.
   task automatic load_rom(input logic [63:0] wn, input logic [15:0] bv);
      for (int g = 0; g < 2; g++) begin
         for (int k = 0; k < 4; k++) begin
            w_rom[g*4+k] = {wn[(g*2+1)*16 +: 16], wn[(g*2)*16 +: 16]};
         end
         b_rom[g] = {bv, bv};
      end
   endtask

   // Ends on the negedge right after the last input handshake; relu_en is then flipped.
   task automatic send_inputs(input logic [15:0] xv, input logic relu);
      for (int i = 0; i < 4; i++) begin
         int w;
         @(negedge CLK);
         in_valid = 1'b1;
         in_data  = xv;
         relu_en  = relu;
         w = 0;
         while (!in_ready && w < 50) begin
            @(negedge CLK);
            w++;
         end
         if (w >= 50) check_eq("in_ready_timeout", {31'd0, in_ready}, 32'd1);
         @(posedge CLK);
      end
      @(negedge CLK);
      in_valid = 1'b0;
      relu_en  = ~relu;
   endtask

   // expv holds output n at [n*16 +: 16]; stall holds out_ready low 5 cycles at output 1.
   task automatic run_infer(input logic [15:0] xv, input logic relu,
                            input logic [63:0] expv, input logic stall);
      int got;
      int cyc;
      logic stalled;
      got = 0;
      cyc = 0;
      stalled = 1'b0;
      out_ready = 1'b1;
      send_inputs(xv, relu);
      while (got < 4 && cyc < 100) begin
         if (cyc > 0) @(negedge CLK);
         cyc++;
         if (out_valid) begin
            if (stall && got == 1 && !stalled) begin
               out_ready = 1'b0;
               for (int s = 0; s < 5; s++) begin
                  @(negedge CLK);
                  check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
                  check_eq("stall_data", {16'd0, out_data}, {16'd0, expv[16 +: 16]});
                  check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
               end
               out_ready = 1'b1;
               stalled = 1'b1;
            end
            check_eq($sformatf("out_data[%0d]", got), {16'd0, out_data}, {16'd0, expv[got*16 +: 16]});
            check_eq($sformatf("out_last[%0d]", got), {31'd0, out_last}, {31'd0, got == 3});
            got++;
         end
      end
      if (got < 4) check_eq("output_count", got, 32'd4);
      repeat (3) begin
         @(negedge CLK);
         check_eq("no_extra_out", {31'd0, out_valid}, 32'd0);
      end
      check_eq("done_busy", {31'd0, busy}, 32'd0);
      check_eq("done_in_ready", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      reset_n   = 1'b0;
      relu_en   = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0000;
      out_ready = 1'b0;
      load_rom({4{16'h0080}}, 16'h0040);
      repeat (2) @(negedge CLK);
      check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_out_last", {31'd0, out_last}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_out_data", {16'd0, out_data}, 32'd0);
      check_eq("rst_w_addr", {29'd0, w_addr}, 32'd0);
      check_eq("rst_b_addr", {31'd0, b_addr}, 32'd0);
      reset_n = 1'b1;

      // Cycle-exact walk: address sequence, latency and data of the basic case.
      out_ready = 1'b1;
      send_inputs(16'h0100, 1'b1);
      for (int k = 1; k <= 17; k++) begin
         if (k > 1) @(negedge CLK);
         case (k)
            1, 2, 3, 4:     check_eq($sformatf("w_addr_k%0d", k), {29'd0, w_addr}, k - 1);
            9, 10, 11, 12:  check_eq($sformatf("w_addr_k%0d", k), {29'd0, w_addr}, k - 5);
            5:              check_eq("b_addr_g0", {31'd0, b_addr}, 32'd0);
            13:             check_eq("b_addr_g1", {31'd0, b_addr}, 32'd1);
            6, 14:          check_eq($sformatf("valid_low_k%0d", k), {31'd0, out_valid}, 32'd0);
            7, 8, 15, 16: begin
               check_eq($sformatf("valid_k%0d", k), {31'd0, out_valid}, 32'd1);
               check_eq($sformatf("data_k%0d", k), {16'd0, out_data}, 32'h0240);
               check_eq($sformatf("last_k%0d", k), {31'd0, out_last}, {31'd0, k == 16});
            end
            17: begin
               check_eq("walk_end_valid", {31'd0, out_valid}, 32'd0);
               check_eq("walk_end_busy", {31'd0, busy}, 32'd0);
               check_eq("walk_end_in_ready", {31'd0, in_ready}, 32'd1);
            end
            default: ;
         endcase
      end

      run_infer(16'h0100, 1'b1, {4{16'h0240}}, 1'b0);

      load_rom({4{16'hFF00}}, 16'h0000);
      run_infer(16'h0100, 1'b1, {4{16'h0000}}, 1'b0);
      run_infer(16'h0100, 1'b0, {4{16'hFC00}}, 1'b0);

      load_rom({4{16'h7FFF}}, 16'h0000);
      run_infer(16'h7FFF, 1'b0, {4{T3_EXP}}, 1'b0);

      load_rom({16'h0100, 16'h00C0, 16'h0080, 16'h0040}, 16'h0040);
      run_infer(16'h0100, 1'b1, {16'h0440, 16'h0340, 16'h0240, 16'h0140}, 1'b1);

      // Reset in the middle of MAC, then a clean rerun.
      load_rom({4{16'h0080}}, 16'h0040);
      send_inputs(16'h0100, 1'b1);
      @(negedge CLK);
      check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
      reset_n = 1'b0;
      #1;
      check_eq("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
      check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      check_eq("mid_rst_w_addr", {29'd0, w_addr}, 32'd0);
      @(negedge CLK);
      reset_n = 1'b1;
      run_infer(16'h0100, 1'b1, {4{16'h0240}}, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
